retospect_cfg_loader: RTL and testbench

- Transmit end of the neurochip configuration scan chain.
- Accepts configuration bytes over a valid/ready handshake, serialises them LSB-first onto the chain input with `cfg_en` asserted, and captures the old chain contents returning on the chain output as readback bytes.
- After the last bit it pulses `reset_nn` to re-arm the neuron array, then signals completion.
- Sits between the host-side byte interface and the clockbox/CNB shift chain.

---
 rtl/retospect_cfg_loader.sv | 111 +++++++++++
 tb/tb_retospect_cfg_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/retospect_cfg_loader.sv
// rtl/retospect_cfg_loader.sv - configuration scan-chain loader with readback capture
// Serialises host bytes LSB-first into the chain and returns the displaced chain contents.
module retospect_cfg_loader #(
   parameter int CHAIN_LEN = 67,
   parameter int CW        = $clog2(CHAIN_LEN + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       cfg_en,
   output logic       bs_out,
   input  logic       bs_in,
   output logic [7:0] rb_data,
   output logic       rb_valid,
   output logic       reset_nn,
   output logic       busy,
   output logic       done,
   output logic       aborted
);

   localparam int NB        = (CHAIN_LEN + 7) / 8;
   localparam int LAST_BITS = CHAIN_LEN - 8 * (NB - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_BYTE,
      S_SHIFT,
      S_NN_RESET,
      S_DONE
   } state_t;

   state_t        state;
   logic [7:0]    tx_sr;
   logic [7:0]    rx_sr;
   logic [7:0]    rx_next;
   logic [CW-1:0] bit_cnt;
   logic [3:0]    bits_left;
   logic [3:0]    byte_bits;
   logic          last_byte;

   assign rx_next   = {bs_in, rx_sr[7:1]};
   assign last_byte = (bit_cnt == CW'(8 * (NB - 1)));

   // Strobe-free outputs decode straight from the state register so they fall with an async reset.
   assign in_ready = (state == S_WAIT_BYTE);
   assign cfg_en   = (state == S_SHIFT);
   assign bs_out   = (state == S_SHIFT) & tx_sr[0];
   assign reset_nn = (state == S_NN_RESET);
   assign done     = (state == S_DONE);
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         tx_sr     <= 8'h00;
         rx_sr     <= 8'h00;
         bit_cnt   <= '0;
         bits_left <= 4'd0;
         byte_bits <= 4'd0;
         rb_data   <= 8'h00;
         rb_valid  <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         aborted  <= 1'b0;
         case (state)
            S_IDLE: begin
               bit_cnt <= '0;
               rx_sr   <= 8'h00;
               if (start) state <= S_WAIT_BYTE;
            end
            S_WAIT_BYTE: begin
               if (abort) begin
                  state   <= S_IDLE;
                  aborted <= 1'b1;
               end else if (in_valid) begin
                  tx_sr     <= in_data;
                  byte_bits <= last_byte ? 4'(LAST_BITS) : 4'd8;
                  bits_left <= last_byte ? 4'(LAST_BITS) : 4'd8;
                  state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (abort) begin
                  state   <= S_IDLE;
                  aborted <= 1'b1;
               end else begin
                  tx_sr     <= {1'b0, tx_sr[7:1]};
                  rx_sr     <= rx_next;
                  bit_cnt   <= bit_cnt + 1'b1;
                  bits_left <= bits_left - 4'd1;
                  if (bits_left == 4'd1) begin
                     // A short final byte sits in the top bits; shift it down and zero-fill.
                     rb_data  <= rx_next >> (4'd8 - byte_bits);
                     rb_valid <= 1'b1;
                     state    <= (bit_cnt == CW'(CHAIN_LEN - 1)) ? S_NN_RESET : S_WAIT_BYTE;
                  end
               end
            end
            S_NN_RESET: state <= S_DONE;
            S_DONE:     state <= S_IDLE;
            default:    state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// tb/tb_retospect_cfg_loader.sv - directed bench for retospect_cfg_loader
// Drives byte loads against a 67-bit chain model and checks stream, readback and strobes.
`timescale 1ns/1ps
module tb_retospect_cfg_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       cfg_en;
   logic       bs_out;
   logic       bs_in;
   logic [7:0] rb_data;
   logic       rb_valid;
   logic       reset_nn;
   logic       busy;
   logic       done;
   logic       aborted;

   retospect_cfg_loader #(.CHAIN_LEN(67)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .cfg_en   (cfg_en),
      .bs_out   (bs_out),
      .bs_in    (bs_in),
      .rb_data  (rb_data),
      .rb_valid (rb_valid),
      .reset_nn (reset_nn),
      .busy     (busy),
      .done     (done),
      .aborted  (aborted)
   );

   always #5 clk = ~clk;

   // Chain model: tail bit feeds bs_in, head takes bs_out on every enabled edge.
   localparam logic [66:0] ALT = 67'h55555555555555555;
   logic [66:0] chain;
   logic        preload = 1'b0;
   assign bs_in = chain[0];
   always @(posedge clk) begin
      if (preload) chain <= ALT;
      else if (cfg_en) chain <= {bs_out, chain[66:1]};
   end

   int         cyc = 0, cfg_cnt = 0, rb_cnt = 0, rn_cnt = 0, done_cnt = 0;
   int         ab_cnt = 0, busy_cnt = 0, rdy_cnt = 0;
   int         last_cfg_cyc = 0, rn_cyc = 0, done_cyc = 0;
   logic       stream [0:2047];
   logic [7:0] rb_arr [0:127];

   always @(negedge clk) begin
      cyc++;
      if (cfg_en) begin stream[cfg_cnt] = bs_out; cfg_cnt++; last_cfg_cyc = cyc; end
      if (rb_valid) begin rb_arr[rb_cnt] = rb_data; rb_cnt++; end
      if (reset_nn) begin rn_cnt++; rn_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (aborted) ab_cnt++;
      if (busy) busy_cnt++;
      if (in_ready) rdy_cnt++;
   end

   int tests = 0, failed = 0;
   logic [7:0] load_data [0:8];
   int b_cfg, b_rb, b_rn, b_done, b_ab, b_busy, b_rdy;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [66:0] get_stream(input int base);
      logic [66:0] v;
      for (int i = 0; i < 67; i++) v[i] = stream[base + i];
      return v;
   endfunction

   task automatic snap();
      b_cfg = cfg_cnt; b_rb = rb_cnt; b_rn = rn_cnt; b_done = done_cnt;
      b_ab = ab_cnt; b_busy = busy_cnt; b_rdy = rdy_cnt;
   endtask

   task automatic do_load(input int gap_at, input int gap_len, input bit spam);
      int idx, gap_left, guard;
      bit hs;
      idx = 0; gap_left = gap_len; guard = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = spam;
      while (done !== 1'b1 && guard < 400) begin
         if (idx == gap_at && gap_left > 0) begin
            in_valid = 1'b0;
            if (in_ready) gap_left--;
         end else if (idx < 9) begin
            in_valid = 1'b1;
            in_data  = load_data[idx];
         end else begin
            in_valid = 1'b0;
         end
         hs = in_valid && in_ready;
         @(negedge clk);
         guard++;
         if (hs) idx++;
      end
      check("load_timeout", guard < 400, 1);
      @(negedge clk); start = 1'b0; in_valid = 1'b0;
      #1;
   endtask

   task automatic set_bytes(input logic [7:0] b, input bit ramp);
      for (int i = 0; i < 9; i++) load_data[i] = ramp ? 8'(i + 1) : b;
   endtask

   initial begin
      int guard;
      reset = 1'b1; start = 1'b0; abort = 1'b0; in_data = 8'h00; in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {in_ready, cfg_en, bs_out, rb_data, rb_valid, reset_nn, busy, done, aborted}, 16'h0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // Basic load 0x01..0x09
      preload = 1'b1; @(negedge clk); preload = 1'b0;
      set_bytes(8'h00, 1'b1);
      snap();
      do_load(99, 0, 1'b0);
      check("basic_cfg_cycles", cfg_cnt - b_cfg, 67);
      check("basic_stream", get_stream(b_cfg), 67'h10807060504030201);
      check("basic_reset_nn", rn_cnt - b_rn, 1);
      check("basic_done", done_cnt - b_done, 1);
      check("basic_rn_after_shift", rn_cyc, last_cfg_cyc + 1);
      check("basic_done_after_rn", done_cyc, rn_cyc + 1);
      check("basic_busy_cycles", busy_cnt - b_busy, 78);
      check("basic_handshakes", rdy_cnt - b_rdy, 9);
      check("basic_rb_count", rb_cnt - b_rb, 9);

      // Readback: alternating chain, then all-ones load, then all-zeros load
      preload = 1'b1; @(negedge clk); preload = 1'b0;
      set_bytes(8'hFF, 1'b0);
      snap();
      do_load(99, 0, 1'b0);
      check("rb1_count", rb_cnt - b_rb, 9);
      for (int i = 0; i < 9; i++)
         check($sformatf("rb1_byte%0d", i), rb_arr[b_rb + i], (i == 8) ? 8'h05 : 8'h55);
      set_bytes(8'h00, 1'b0);
      snap();
      do_load(99, 0, 1'b0);
      check("rb2_count", rb_cnt - b_rb, 9);
      for (int i = 0; i < 9; i++)
         check($sformatf("rb2_byte%0d", i), rb_arr[b_rb + i], (i == 8) ? 8'h07 : 8'hFF);

      // Backpressure: five idle WAIT_BYTE cycles before byte 4
      set_bytes(8'h00, 1'b1);
      snap();
      do_load(3, 5, 1'b0);
      check("bp_cfg_cycles", cfg_cnt - b_cfg, 67);
      check("bp_stream", get_stream(b_cfg), 67'h10807060504030201);
      check("bp_busy_cycles", busy_cnt - b_busy, 83);
      check("bp_ready_cycles", rdy_cnt - b_rdy, 14);
      check("bp_done", done_cnt - b_done, 1);

      // Abort in 4th SHIFT cycle of byte 2
      snap();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
      @(negedge clk); in_valid = 1'b0;
      guard = 0;
      while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
      check("abort_wait_ready", in_ready, 1);
      in_valid = 1'b1; in_data = 8'h3C;
      @(negedge clk); in_valid = 1'b0;
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("abort_idle", {busy, cfg_en}, 2'b00);
      check("abort_strobe", aborted, 1);
      @(negedge clk); #1;
      check("abort_cfg_cycles", cfg_cnt - b_cfg, 12);
      check("abort_rb_count", rb_cnt - b_rb, 1);
      check("abort_no_rn_done", {rn_cnt - b_rn, done_cnt - b_done}, 0);
      check("abort_once", ab_cnt - b_ab, 1);

      // Abort wins over a handshake in WAIT_BYTE
      snap();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'h77; abort = 1'b1;
      @(negedge clk); in_valid = 1'b0; abort = 1'b0;
      check("abort_wait_state", {busy, cfg_en, aborted}, 3'b001);
      @(negedge clk); #1;
      check("abort_wait_no_shift", cfg_cnt - b_cfg, 0);

      // Load after abort completes normally
      snap();
      do_load(99, 0, 1'b0);
      check("post_abort_done", done_cnt - b_done, 1);
      check("post_abort_stream", get_stream(b_cfg), 67'h10807060504030201);

      // Asynchronous reset mid-shift
      snap();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_outputs", {in_ready, cfg_en, bs_out, rb_data, rb_valid, reset_nn, busy, done, aborted}, 16'h0);
      @(negedge clk); in_valid = 1'b0; start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_start_ignored", {busy, in_ready}, 2'b00);
      start = 1'b0; reset = 1'b0;
      @(negedge clk); #1;
      check("rst_released_idle", busy, 0);
      check("rst_no_strobes", {rn_cnt - b_rn, done_cnt - b_done, rb_cnt - b_rb}, 0);

      // Start pulses while busy are ignored
      snap();
      do_load(99, 0, 1'b1);
      repeat (3) @(negedge clk);
      #1;
      check("spam_done_once", done_cnt - b_done, 1);
      check("spam_rn_once", rn_cnt - b_rn, 1);
      check("spam_idle_after", busy, 0);
      check("spam_cfg_cycles", cfg_cnt - b_cfg, 67);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
